rr_arbitrated_fifo: RTL and testbench
=====================================

// Module: rr_arbitrated_fifo
// PURPOSE
//  Multi-channel FIFO: NCH independent queues, each with its own push port.
//  One shared valid/ready output port, served by a round-robin arbiter.
//  Adds almost-full flags, sticky per-channel overflow flags and a
//  grant lock, so the output is stable under backpressure.
//  Sits between NCH producers and a single consumer.
// PARAMETERS
//  WIDTH        8          data width per entry
//  DEPTH        8          entries per channel; power of 2, >=2
//  NCH          4          number of channels; >=2
//  AFULL_THRESH DEPTH-2    afull[c] asserts when cnt[c] >= AFULL_THRESH (1..DEPTH)
// PORTS
//  clk       in   1               single clock, rising edge
//  rst       in   1               reset, asynchronous, active-low (0 = reset)
//  push      in   NCH             per-channel write strobe
//  data_in   in   NCH*WIDTH       channel c data = data_in[c*WIDTH +: WIDTH]
//  full      out  NCH             cnt[c] == DEPTH
//  afull     out  NCH             cnt[c] >= AFULL_THRESH
//  out_valid out  1               some channel is non-empty
//  out_ready in   1               consumer accepts data_out this cycle
//  data_out  out  WIDTH           head entry of the granted channel
//  out_ch    out  $clog2(NCH)     index of the granted channel
//  ovf       out  NCH             sticky: a push was dropped on channel c
//  clr_ovf   in   NCH             synchronous clear of ovf bits
// BEHAVIOUR
//  Per channel:
//   - cnt is $clog2(DEPTH)+1 bits wide.
//   - rd/wr indices are $clog2(DEPTH) bits and wrap modulo DEPTH.
//  Push:
//   - Accepted iff push[c] & !full[c]; entry written at wr index, which then increments.
//   - Push while full is dropped: no state change except ovf[c] <= 1.
//   - full is never relieved by a same-cycle pop.
//  Pop:
//   - Occurs only on transfer (out_valid & out_ready), on channel out_ch.
//   - rd index of that channel increments.
//  Simultaneous accepted push and pop on one channel: both happen, cnt unchanged.
//  Latency: a pushed entry is visible at the output the next cycle. No bypass.
//  Arbitration:
//   - last_grant register, reset value NCH-1, so channel 0 wins first.
//   - Unlocked: grant = first non-empty channel scanning last_grant+1,
//     last_grant+2, ... mod NCH.
//   - Lock: if out_valid & !out_ready, the grant is locked next cycle.
//     While locked, out_ch and data_out hold even if new pushes arrive;
//     the lock releases on transfer.
//   - On transfer: last_grant <= out_ch.
//  Outputs:
//   - out_valid = OR of non-empty channels. It never drops without a transfer.
//   - data_out/out_ch are 0 when out_valid = 0.
//  ovf:
//   - clr_ovf[c] clears ovf[c].
//   - A same-cycle drop wins over clear: ovf stays 1.
//  Reset (rst = 0, async):
//   - cnt, pointers, entries, ovf, lock -> 0; last_grant -> NCH-1.
//   - Outputs immediately: full = 0, afull = 0, out_valid = 0, data_out = 0,
//     out_ch = 0, ovf = 0.
//   - Reset mid-operation discards all contents with no clock edge needed.
//   - Deassertion is synchronised upstream.
// TESTING
//  1. Reset: assert rst = 0 between edges -> outputs at reset values before the next posedge.
//  2. Fill ch0 with 1..8 (DEPTH = 8):
//     - afull[0] rises after the 6th push; full[0] rises after the 8th.
//     - A 9th push of 0xFF is dropped and ovf[0] = 1.
//     - Drain returns 1..8; clr_ovf[0] -> ovf[0] = 0.
//  3. Same-cycle pushes ch0 = 0xA, ch1 = 0xB, ch3 = 0xC with out_ready = 1
//     -> out_ch sequence 0, 1, 3 and data 0xA, 0xB, 0xC.
//  4. Hold out_ready = 0 with ch2 granted, then push ch0
//     -> out_ch stays 2 and data_out stays stable until out_ready = 1.
//  5. Fairness: keep ch0 always non-empty, one entry in ch3
//     -> ch3 transfers within NCH = 4 transfers.
//  6. Wrap: 20 push/pop pairs on ch1 at full rate
//     -> cnt stays 1, data order is preserved, no ovf.

Source files
------------

// File: rtl/rr_arbitrated_fifo_if.sv
// ============================================================================
//  Module   : rr_arbitrated_fifo_if
//  Brief    : Producer/consumer bus of the multi-channel round-robin FIFO.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface rr_arbitrated_fifo_if #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4
);
   localparam int CW = $clog2(NCH);

   logic [NCH-1:0]       i_push;
   logic [NCH*WIDTH-1:0] i_data_in;
   logic [NCH-1:0]       o_full;
   logic [NCH-1:0]       o_afull;
   logic                 o_out_valid;
   logic                 i_out_ready;
   logic [WIDTH-1:0]     o_data_out;
   logic [CW-1:0]        o_out_ch;
   logic [NCH-1:0]       o_ovf;
   logic [NCH-1:0]       i_clr_ovf;

   modport slave (
      input  i_push, i_data_in, i_out_ready, i_clr_ovf,
      output o_full, o_afull, o_out_valid, o_data_out, o_out_ch, o_ovf
   );

   modport master (
      output i_push, i_data_in, i_out_ready, i_clr_ovf,
      input  o_full, o_afull, o_out_valid, o_data_out, o_out_ch, o_ovf
   );
endinterface

`default_nettype wire

// File: rtl/rr_arbitrated_fifo.sv
// ============================================================================
//  Module   : rr_arbitrated_fifo
//  Brief    : NCH independent FIFOs drained through one round-robin,
//             grant-locked valid/ready output port.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbitrated_fifo #(
   parameter int WIDTH        = 8,
   parameter int DEPTH        = 8,
   parameter int NCH          = 4,
   parameter int AFULL_THRESH = DEPTH - 2
) (
   input  logic                  clk,
   input  logic                  rst,
   rr_arbitrated_fifo_if.slave   bus
);
   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = AW + 1;
   localparam int CW   = $clog2(NCH);

   logic [NCH-1:0]   w_ne;
   logic [NCH-1:0]   w_full;
   logic [NCH-1:0]   w_afull;
   logic [NCH-1:0]   w_ovf;
   logic [NCH-1:0]   w_push_ok;
   logic [NCH-1:0]   w_pop;
   logic [WIDTH-1:0] w_head [NCH];
   logic [CW-1:0]    w_grant;
   logic             w_valid;
   logic             w_xfer;

   logic [CW-1:0]    r_last;
   logic             r_lock;
   logic [CW-1:0]    r_lock_ch;

   assign w_valid = |w_ne;
   assign w_xfer  = w_valid & bus.i_out_ready;

   // A locked grant always points at a non-empty channel: pops only happen on transfer.
   always_comb begin
      logic          v_found;
      logic [CW-1:0] v_idx;
      w_grant = '0;
      v_found = 1'b0;
      v_idx   = '0;
      if (r_lock) begin
         w_grant = r_lock_ch;
      end else begin
         for (int i = 1; i <= NCH; i++) begin
            v_idx = CW'((int'(r_last) + i) % NCH);
            if (!v_found && w_ne[v_idx]) begin
               w_grant = v_idx;
               v_found = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last    <= CW'(NCH - 1);
         r_lock    <= 1'b0;
         r_lock_ch <= '0;
      end else begin
         r_lock <= w_valid & ~bus.i_out_ready;
         if (w_valid & ~bus.i_out_ready) begin
            r_lock_ch <= w_grant;
         end
         if (w_xfer) begin
            r_last <= w_grant;
         end
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [AW-1:0]    r_rd;
      logic [AW-1:0]    r_wr;
      logic [CNTW-1:0]  r_cnt;
      logic             r_ovf;
      logic [WIDTH-1:0] w_din;

      assign w_din        = bus.i_data_in[c*WIDTH +: WIDTH];
      assign w_full[c]    = (r_cnt == CNTW'(DEPTH));
      assign w_afull[c]   = (r_cnt >= CNTW'(AFULL_THRESH));
      assign w_ne[c]      = (r_cnt != '0);
      assign w_ovf[c]     = r_ovf;
      assign w_push_ok[c] = bus.i_push[c] & ~w_full[c];
      assign w_pop[c]     = w_xfer & (w_grant == CW'(c));
      assign w_head[c]    = r_mem[r_rd];

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
               r_mem[k] <= '0;
            end
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
         end else begin
            if (w_push_ok[c]) begin
               r_mem[r_wr] <= w_din;
               r_wr        <= r_wr + 1'b1;
            end
            if (w_pop[c]) begin
               r_rd <= r_rd + 1'b1;
            end
            if (w_push_ok[c] && !w_pop[c]) begin
               r_cnt <= r_cnt + 1'b1;
            end else if (!w_push_ok[c] && w_pop[c]) begin
               r_cnt <= r_cnt - 1'b1;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (bus.i_push[c] && w_full[c]) begin
               r_ovf <= 1'b1;
            end else if (bus.i_clr_ovf[c]) begin
               r_ovf <= 1'b0;
            end
         end
      end
   end

   assign bus.o_full      = w_full;
   assign bus.o_afull     = w_afull;
   assign bus.o_ovf       = w_ovf;
   assign bus.o_out_valid = w_valid;
   assign bus.o_out_ch    = w_valid ? w_grant : '0;
   assign bus.o_data_out  = w_valid ? w_head[w_grant] : '0;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbitrated_fifo.sv
// ============================================================================
//  Module   : tb_rr_arbitrated_fifo
//  Brief    : Directed and random stimulus against a queue-based model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rr_arbitrated_fifo;
   localparam int W  = 8;
   localparam int D  = 8;
   localparam int N  = 4;
   localparam int AF = D - 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   rr_arbitrated_fifo_if #(.WIDTH(W), .NCH(N)) bus ();

   rr_arbitrated_fifo #(
      .WIDTH(W), .DEPTH(D), .NCH(N), .AFULL_THRESH(AF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [W-1:0] q [N][$];
   int           m_last;
   bit           m_lock;
   int           m_lock_ch;
   logic [N-1:0] m_ovf;

   int           n_asrt = 0;
   int           n_fail = 0;
   int           obs_ch;
   logic         obs_valid;
   logic [W-1:0] obs_data;

   function automatic bit m_valid();
      for (int c = 0; c < N; c++) if (q[c].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int m_grant();
      if (m_lock) return m_lock_ch;
      for (int i = 1; i <= N; i++) begin
         int c = (m_last + i) % N;
         if (q[c].size() != 0) return c;
      end
      return 0;
   endfunction

   function automatic logic [N*W-1:0] mk(input int c, input logic [W-1:0] v);
      logic [N*W-1:0] r = '0;
      r[c*W +: W] = v;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < N; c++) q[c].delete();
      m_last    = N - 1;
      m_lock    = 1'b0;
      m_lock_ch = 0;
      m_ovf     = '0;
   endtask

   task automatic check_outputs();
      bit           v = m_valid();
      int           g = v ? m_grant() : 0;
      logic [W-1:0] e = v ? q[g][0] : '0;
      logic [N-1:0] ef, ea;
      for (int c = 0; c < N; c++) begin
         ef[c] = (q[c].size() == D);
         ea[c] = (q[c].size() >= AF);
      end
      chk("out_valid", 32'(bus.o_out_valid), 32'(v));
      chk("out_ch",    32'(bus.o_out_ch),    32'(g));
      chk("data_out",  32'(bus.o_data_out),  32'(e));
      chk("full",      32'(bus.o_full),      32'(ef));
      chk("afull",     32'(bus.o_afull),     32'(ea));
      chk("ovf",       32'(bus.o_ovf),       32'(m_ovf));
      obs_ch    = int'(bus.o_out_ch);
      obs_valid = bus.o_out_valid;
      obs_data  = bus.o_data_out;
   endtask

   task automatic model_update(input logic [N-1:0] p, input logic [N*W-1:0] d,
                               input logic rdy, input logic [N-1:0] clr);
      bit           v = m_valid();
      int           g = v ? m_grant() : 0;
      logic [N-1:0] fv;
      for (int c = 0; c < N; c++) fv[c] = (q[c].size() == D);
      if (v && rdy) begin
         void'(q[g].pop_front());
         m_last = g;
      end
      m_lock = v && !rdy;
      if (m_lock) m_lock_ch = g;
      for (int c = 0; c < N; c++) begin
         if (p[c] && !fv[c]) q[c].push_back(d[c*W +: W]);
         if (p[c] && fv[c])  m_ovf[c] = 1'b1;
         else if (clr[c])    m_ovf[c] = 1'b0;
      end
   endtask

   // Called at posedge+1; checks mid-cycle, then lets the edge apply the inputs.
   task automatic step(input logic [N-1:0] p, input logic [N*W-1:0] d,
                       input logic rdy, input logic [N-1:0] clr);
      bus.i_push      = p;
      bus.i_data_in   = d;
      bus.i_out_ready = rdy;
      bus.i_clr_ovf   = clr;
      #4;
      check_outputs();
      model_update(p, d, rdy, clr);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 64 && m_valid(); k++) step('0, '0, 1'b1, '0);
      chk("drain_bound", 32'(m_valid()), 32'd0);
   endtask

   task automatic async_reset();
      bus.i_push = '0; bus.i_out_ready = 1'b0; bus.i_clr_ovf = '0;
      rst = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      int seen, xfers;
      logic [W-1:0] exp3 [3];
      int           ch3  [3];
      bus.i_push = '0; bus.i_data_in = '0; bus.i_out_ready = 1'b0; bus.i_clr_ovf = '0;
      #2;
      model_reset();
      check_outputs();
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Fill channel 0, overflow, drain, clear
      for (int i = 1; i <= D; i++) begin
         step(4'b0001, mk(0, W'(i)), 1'b0, '0);
         chk("afull0", 32'(bus.o_afull[0]), 32'(i >= AF));
         chk("full0",  32'(bus.o_full[0]),  32'(i == D));
      end
      step(4'b0001, mk(0, 8'hFF), 1'b0, '0);
      chk("ovf0_set", 32'(bus.o_ovf[0]), 32'd1);
      for (int i = 1; i <= D; i++) begin
         step('0, '0, 1'b1, '0);
         chk("drain0", 32'(obs_data), 32'(i));
      end
      step('0, '0, 1'b0, 4'b0001);
      chk("ovf0_clr", 32'(bus.o_ovf[0]), 32'd0);

      // Reset in the middle of traffic
      step(4'b0100, mk(2, 8'h55), 1'b0, '0);
      step(4'b0100, mk(2, 8'h66), 1'b0, '0);
      async_reset();

      // Same-cycle pushes on 0, 1, 3
      step(4'b1011, mk(0, 8'h0A) | mk(1, 8'h0B) | mk(3, 8'h0C), 1'b1, '0);
      exp3 = '{8'h0A, 8'h0B, 8'h0C};
      ch3  = '{0, 1, 3};
      for (int i = 0; i < 3; i++) begin
         step('0, '0, 1'b1, '0);
         chk("rr_ch",   32'(obs_ch),   32'(ch3[i]));
         chk("rr_data", 32'(obs_data), 32'(exp3[i]));
      end

      // Lock under backpressure
      step(4'b0100, mk(2, 8'h22), 1'b0, '0);
      step(4'b0001, mk(0, 8'h11), 1'b0, '0);
      chk("lock_ch_a", 32'(obs_ch), 32'd2);
      step('0, '0, 1'b0, '0);
      chk("lock_ch_b",   32'(obs_ch),   32'd2);
      chk("lock_data_b", 32'(obs_data), 32'h22);
      step('0, '0, 1'b1, '0);
      chk("lock_release", 32'(obs_ch), 32'd2);
      drain();

      // Fairness: ch0 always busy, one entry on ch3
      step(4'b1001, mk(0, 8'h01) | mk(3, 8'h33), 1'b0, '0);
      seen = 0; xfers = 0;
      while (xfers < N && seen == 0) begin
         step(4'b0001, mk(0, 8'h01), 1'b1, '0);
         if (obs_valid) xfers++;
         if (obs_valid && obs_ch == 3) seen = 1;
      end
      chk("fairness", 32'(seen), 32'd1);
      drain();

      // Wrap on ch1 at full rate
      step(4'b0010, mk(1, 8'h80), 1'b1, '0);
      for (int i = 1; i <= 20; i++) step(4'b0010, mk(1, W'(8'h80 + i)), 1'b1, '0);
      chk("wrap_ovf", 32'(bus.o_ovf), 32'd0);
      drain();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(N'($urandom), {$urandom}, ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 7) == 0) ? N'($urandom) : '0);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
